pipe_hazard_ctrl: RTL and testbench

- Hazard and sequencing controller for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB).
- Generates per-stage stall/flush controls and operand-forwarding selects.
- Arbitrates three sources in priority order: bus wait-states, EX-stage PC redirects, data hazards.
- Keeps saturating event counters and a bus-wait watchdog for debug/trace.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 12 +
 rtl/hazard_match.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 80 ++++++++
 tb/tb_pipe_hazard_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: forwarding-source and hazard FSM state encodings shared by the hazard controller.
package pipe_hazard_ctrl_pkg;
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;
    typedef enum logic [1:0] {
        HZ_RUN    = 2'd0,
        HZ_DSTALL = 2'd1,
        HZ_MWAIT  = 2'd2
    } hz_state_t;
endpackage

// File: rtl/hazard_match.sv
// hazard_match: per-operand producer match, hazard detect and forward select.
// PIPE_FWD_EN defined: only load-use stalls, operands forwarded youngest-first; undefined: any match stalls.
module hazard_match
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic       re,
    input  logic [4:0] ex_wR,
    input  logic       ex_rf_we,
    input  logic       ex_is_load,
    input  logic [4:0] mem_wR,
    input  logic       mem_rf_we,
    input  logic [4:0] wb_wR,
    input  logic       wb_rf_we,
    output logic       hazard,
    output logic [1:0] fwd_sel
);
    logic m_ex, m_mem, m_wb, load_use, alu_ex;
    // x0 is hardwired, so a write to it is never a real producer
    assign m_ex     = re && ex_rf_we  && ex_wR  != 5'd0 && ex_wR  == rs;
    assign m_mem    = re && mem_rf_we && mem_wR != 5'd0 && mem_wR == rs;
    assign m_wb     = re && wb_rf_we  && wb_wR  != 5'd0 && wb_wR  == rs;
    assign load_use = m_ex && ex_is_load;
    assign alu_ex   = m_ex && !ex_is_load;
`ifdef PIPE_FWD_EN
    assign hazard  = load_use;
    assign fwd_sel = alu_ex ? FWD_EX : m_mem ? FWD_MEM : m_wb ? FWD_WB : FWD_RF;
`else
    assign hazard  = load_use || alu_ex || m_mem || m_wb;
    assign fwd_sel = FWD_RF;
`endif
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline stall/flush/forward control with event counters and bus-wait watchdog.
// Forwarding is enabled by defining PIPE_FWD_EN.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int WAIT_MAX = 255
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_re1,
    input  logic             id_re2,
    input  logic [4:0]       ex_wR,
    input  logic             ex_rf_we,
    input  logic             ex_is_load,
    input  logic [4:0]       mem_wR,
    input  logic             mem_rf_we,
    input  logic [4:0]       wb_wR,
    input  logic             wb_rf_we,
    input  logic             ex_redirect,
    input  logic             mem_wait,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             freeze_all,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [1:0]       hz_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt,
    output logic             bus_err
);
    logic        hz_a, hz_b, redir_act, dstall;
    logic [15:0] run, run_nxt;
    hz_state_t   state, state_nxt;
    hazard_match u_match_a (
        .rs(id_rs1), .re(id_re1), .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load),
        .mem_wR(mem_wR), .mem_rf_we(mem_rf_we), .wb_wR(wb_wR), .wb_rf_we(wb_rf_we),
        .hazard(hz_a), .fwd_sel(fwd_a_sel)
    );
    hazard_match u_match_b (
        .rs(id_rs2), .re(id_re2), .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load),
        .mem_wR(mem_wR), .mem_rf_we(mem_rf_we), .wb_wR(wb_wR), .wb_rf_we(wb_rf_we),
        .hazard(hz_b), .fwd_sel(fwd_b_sel)
    );
    // bus wait outranks redirect, which outranks data hazards
    assign redir_act   = !mem_wait && ex_redirect;
    assign dstall      = !mem_wait && !ex_redirect && (hz_a || hz_b);
    assign stall_pc    = mem_wait || dstall;
    assign stall_if_id = mem_wait || dstall;
    assign flush_if_id = redir_act;
    assign flush_id_ex = redir_act || dstall;
    assign freeze_all  = mem_wait;
    assign hz_state    = state;
    always_comb begin
        state_nxt = mem_wait ? HZ_MWAIT : dstall ? HZ_DSTALL : HZ_RUN;
        run_nxt   = !mem_wait ? 16'd0 : (run == 16'hffff) ? run : run + 16'd1;
    end
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state     <= HZ_RUN;
            run       <= 16'd0;
            bus_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            run       <= run_nxt;
            bus_err   <= bus_err || run_nxt == 16'(WAIT_MAX);
            stall_cnt <= stall_cnt + CNT_W'(dstall && stall_cnt != '1);
            flush_cnt <= flush_cnt + CNT_W'(redir_act && flush_cnt != '1);
            wait_cnt  <= wait_cnt + CNT_W'(mem_wait && wait_cnt != '1);
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: vector table plus clocked corner-case sequences, checked through an expected-value queue.
module tb_pipe_hazard_ctrl;
`ifdef PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int CW = 4;
    typedef struct {
        logic [4:0] rs1, rs2;
        logic       re1, re2;
        logic [4:0] ex_wr;
        logic       ex_we, ex_ld;
        logic [4:0] mem_wr;
        logic       mem_we;
        logic [4:0] wb_wr;
        logic       wb_we;
        logic       redir, mwait;
        logic [4:0] ctl_nf, ctl_f;
        logic [1:0] fa_f, fb_f;
    } vec_t;
    typedef struct {
        logic [4:0] ctl;
        logic [1:0] fa, fb;
    } exp_t;

    logic cpu_clk = 1'b0, cpu_rst = 1'b0;
    logic [4:0] id_rs1, id_rs2, ex_wR, mem_wR, wb_wR;
    logic id_re1, id_re2, ex_rf_we, ex_is_load, mem_rf_we, wb_rf_we, ex_redirect, mem_wait;
    logic stall_pc, stall_if_id, flush_if_id, flush_id_ex, freeze_all, bus_err;
    logic [1:0] fwd_a_sel, fwd_b_sel, hz_state;
    logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt;
    int tests = 0, fails = 0;
    exp_t exp_q[$];
    vec_t tbl[12];
    vec_t idle, v;

    pipe_hazard_ctrl #(.CNT_W(CW), .WAIT_MAX(4)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_re1(id_re1), .id_re2(id_re2), .ex_wR(ex_wR), .ex_rf_we(ex_rf_we),
        .ex_is_load(ex_is_load), .mem_wR(mem_wR), .mem_rf_we(mem_rf_we), .wb_wR(wb_wR),
        .wb_rf_we(wb_rf_we), .ex_redirect(ex_redirect), .mem_wait(mem_wait),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .freeze_all(freeze_all), .fwd_a_sel(fwd_a_sel),
        .fwd_b_sel(fwd_b_sel), .hz_state(hz_state), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt), .wait_cnt(wait_cnt), .bus_err(bus_err)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t d);
        id_rs1 = d.rs1; id_rs2 = d.rs2; id_re1 = d.re1; id_re2 = d.re2;
        ex_wR = d.ex_wr; ex_rf_we = d.ex_we; ex_is_load = d.ex_ld;
        mem_wR = d.mem_wr; mem_rf_we = d.mem_we; wb_wR = d.wb_wr; wb_rf_we = d.wb_we;
        ex_redirect = d.redir; mem_wait = d.mwait;
    endtask

    // drive one cycle, queue its expectation, compare at the falling edge, end just after the next rising edge
    task automatic cycle(input vec_t d, input string name);
        exp_t e, got;
        drive(d);
        e.ctl = FWD ? d.ctl_f : d.ctl_nf;
        e.fa  = FWD ? d.fa_f : 2'd0;
        e.fb  = FWD ? d.fb_f : 2'd0;
        exp_q.push_back(e);
        @(negedge cpu_clk);
        got = exp_q.pop_front();
        check({name, ".ctl"}, {stall_pc, stall_if_id, flush_if_id, flush_id_ex, freeze_all}, got.ctl);
        check({name, ".fwd_a"}, fwd_a_sel, got.fa);
        check({name, ".fwd_b"}, fwd_b_sel, got.fb);
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic reset_dut();
        drive(idle);
        @(negedge cpu_clk);
        cpu_rst = 1'b1;
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        @(posedge cpu_clk);
        #1;
    endtask

    initial begin
        idle = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
                 5'b00000, 5'b00000, 2'd0, 2'd0};
        // rs1 rs2 re1 re2 | ex wr we ld | mem wr we | wb wr we | redir mwait | ctl_nf ctl_f fa fb
        tbl[0]  = idle;
        tbl[1]  = '{5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11010, 5'b00000, 2'd1, 2'd0};
        tbl[2]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 2'd0, 2'd0};
        tbl[3]  = '{5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11010, 5'b11010, 2'd0, 2'd0};
        tbl[4]  = '{5'd1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11010, 5'b00000, 2'd0, 2'd2};
        tbl[5]  = '{5'd9, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 5'b11010, 5'b00000, 2'd3, 2'd2};
        tbl[6]  = '{5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11010, 5'b00000, 2'd1, 2'd0};
        tbl[7]  = '{5'd3, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 2'd0, 2'd0};
        tbl[8]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'b00110, 5'b00110, 2'd0, 2'd0};
        tbl[9]  = '{5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'b11001, 5'b11001, 2'd1, 2'd0};
        tbl[10] = '{5'd8, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 2'd0, 2'd0};
        tbl[11] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11010, 5'b11010, 2'd2, 2'd0};

        reset_dut();
        check("rst.hz_state", hz_state, 0);
        check("rst.stall_cnt", stall_cnt, 0);
        check("rst.flush_cnt", flush_cnt, 0);
        check("rst.wait_cnt", wait_cnt, 0);
        check("rst.bus_err", bus_err, 0);

        for (int i = 0; i < 12; i++) cycle(tbl[i], $sformatf("vec%0d", i));

        // load-use: producer moves EX -> MEM -> WB while ID keeps reading x5
        reset_dut();
        v = idle; v.rs1 = 5'd5; v.re2 = 1'b0;
        v.ex_wr = 5'd5; v.ex_we = 1'b1; v.ex_ld = 1'b1; v.ctl_nf = 5'b11010; v.ctl_f = 5'b11010;
        cycle(v, "lu.c1");
        check("lu.state1", hz_state, 1);
        v.ex_we = 1'b0; v.ex_ld = 1'b0; v.mem_wr = 5'd5; v.mem_we = 1'b1; v.ctl_f = 5'b00000; v.fa_f = 2'd2;
        cycle(v, "lu.c2");
        check("lu.state2", hz_state, FWD ? 0 : 1);
        v.mem_we = 1'b0; v.wb_wr = 5'd5; v.wb_we = 1'b1; v.fa_f = 2'd3;
        cycle(v, "lu.c3");
        v.wb_we = 1'b0; v.ctl_nf = 5'b00000; v.fa_f = 2'd0;
        cycle(v, "lu.c4");
        check("lu.stall_cnt", stall_cnt, FWD ? 1 : 3);
        check("lu.state4", hz_state, 0);

        // ALU back-to-back on x3
        reset_dut();
        v = idle; v.rs1 = 5'd3; v.re2 = 1'b0;
        v.ex_wr = 5'd3; v.ex_we = 1'b1; v.ctl_nf = 5'b11010; v.fa_f = 2'd1;
        cycle(v, "alu.c1");
        v.ex_we = 1'b0; v.mem_wr = 5'd3; v.mem_we = 1'b1; v.fa_f = 2'd2;
        cycle(v, "alu.c2");
        v.mem_we = 1'b0; v.wb_wr = 5'd3; v.wb_we = 1'b1; v.fa_f = 2'd3;
        cycle(v, "alu.c3");
        check("alu.stall_cnt", stall_cnt, FWD ? 0 : 3);

        // redirect coinciding with load-use
        reset_dut();
        cycle(tbl[8], "rdlu");
        check("rdlu.flush_cnt", flush_cnt, 1);
        check("rdlu.stall_cnt", stall_cnt, 0);
        check("rdlu.state", hz_state, 0);

        // redirect held off by three wait cycles
        reset_dut();
        v = idle; v.redir = 1'b1; v.mwait = 1'b1; v.ctl_nf = 5'b11001; v.ctl_f = 5'b11001;
        for (int i = 0; i < 3; i++) begin
            cycle(v, $sformatf("mw.c%0d", i));
            check("mw.wait_cnt", wait_cnt, i + 1);
            check("mw.flush_cnt", flush_cnt, 0);
        end
        check("mw.state", hz_state, 2);
        v.mwait = 1'b0; v.ctl_nf = 5'b00110; v.ctl_f = 5'b00110;
        cycle(v, "mw.c3");
        check("mw.flush_cnt4", flush_cnt, 1);
        check("mw.wait_cnt4", wait_cnt, 3);
        check("mw.bus_err", bus_err, 0);

        // watchdog trips on the 4th consecutive wait edge and is sticky
        reset_dut();
        v = idle; v.mwait = 1'b1; v.ctl_nf = 5'b11001; v.ctl_f = 5'b11001;
        for (int i = 0; i < 6; i++) begin
            cycle(v, "wd.wait");
            check($sformatf("wd.bus_err%0d", i), bus_err, i >= 3 ? 1 : 0);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(idle, "wd.idle");
            check("wd.sticky", bus_err, 1);
        end
        cycle(v, "wd.wait2");
        check("wd.state", hz_state, 2);
        @(negedge cpu_clk);
        drive(v);
        cpu_rst = 1'b1;
        #1;
        check("arst.bus_err", bus_err, 0);
        check("arst.wait_cnt", wait_cnt, 0);
        check("arst.state", hz_state, 0);
        check("arst.stall_pc", stall_pc, 1);
        check("arst.freeze", freeze_all, 1);
        @(posedge cpu_clk);
        #1;
        check("arst.held_cnt", wait_cnt, 0);
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        @(posedge cpu_clk);
        #1;
        check("arst.release_cnt", wait_cnt, 1);

        // counter saturation
        reset_dut();
        for (int i = 0; i < 20; i++) cycle(v, "sat.wait");
        check("sat.wait_cnt", wait_cnt, 15);
        check("sat.bus_err", bus_err, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
